// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Action taken in a cycle; the encoding is visible on hazard_state.
    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StFlush     = 2'd2,
        StMemWait   = 2'd3
    } hazard_state_t;

    localparam logic [4:0]  REG_ZERO             = 5'd0;
    localparam int unsigned WAIT_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: counts cycles with inc_i high, wraps modulo 2^Width.
module perf_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: step on each qualifying cycle, natural wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / redirect controller for the five-stage core.
// Priority each cycle: memory wait > EX redirect > load-use stall > run.
// Optional HAZARD_PERF_EN adds stall/flush/wait performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_hazard,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_stall,
    output logic       exmem_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_flush,
    output logic       pc_redirect,
    output logic [1:0] hazard_state,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
`endif
);

    localparam int unsigned WaitW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_TIMEOUT);

    hazard_state_t    state_q, state_d;
    logic             load_use;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;

    // State register: remembers the action chosen in the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the prioritised action selected this cycle.
    always_comb begin
        // A load that already produced its bubble is stale in EX; never stall on it twice.
        load_use = ex_hazard && ex_reg_write && (ex_rd != REG_ZERO) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd))) &&
                   (state_q != StLoadStall);
        if (mem_req && !mem_ready) begin
            state_d = StMemWait;
        end else if (ex_redirect) begin
            state_d = StFlush;
        end else if (load_use) begin
            state_d = StLoadStall;
        end else begin
            state_d = StRun;
        end
    end

    // Mealy outputs decoded from the action selected this cycle; silenced in reset.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        pc_redirect = 1'b0;
        if (!rst) begin
            unique case (state_d)
                StMemWait: begin
                    // Freeze everything up to EX; a pending redirect waits in EX.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_flush = 1'b1;
                end
                StFlush: begin
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end
                StLoadStall: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
                StRun: begin
                end
            endcase
        end
    end

    // Watchdog next state: count consecutive waits, saturate, latch the timeout.
    always_comb begin
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if (state_d == StMemWait) begin
            if (wait_q == WaitMax) begin
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end else begin
            wait_d = '0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign hazard_state = state_q;
    assign mem_timeout  = timeout_q;

`ifdef HAZARD_PERF_EN
    perf_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk),
        .rst_i(rst),
        .inc_i(state_d == StLoadStall),
        .cnt_o(stall_cnt)
    );

    perf_counter #(
        .Width(CNT_W)
    ) u_flush_cnt (
        .clk_i(clk),
        .rst_i(rst),
        .inc_i(state_d == StFlush),
        .cnt_o(flush_cnt)
    );

    perf_counter #(
        .Width(CNT_W)
    ) u_wait_cnt (
        .clk_i(clk),
        .rst_i(rst),
        .inc_i(state_d == StMemWait),
        .cnt_o(wait_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed literal checks plus a
// randomized run compared every negedge against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned WT = 4;
    localparam int unsigned CW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic       ex_hazard = 1'b0, ex_reg_write = 1'b0, ex_redirect = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b1;
    logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic       ifid_flush, idex_flush, memwb_flush, pc_redirect;
    logic [1:0] hazard_state;
    logic       mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    pipeline_hazard_ctrl #(
        .WAIT_TIMEOUT(WT),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .ex_hazard(ex_hazard),
        .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd),
        .ex_redirect(ex_redirect),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .pc_stall(pc_stall),
        .ifid_stall(ifid_stall),
        .idex_stall(idex_stall),
        .exmem_stall(exmem_stall),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .memwb_flush(memwb_flush),
        .pc_redirect(pc_redirect),
        .hazard_state(hazard_state),
        .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .wait_cnt(wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] out_vec();
        return {pc_stall, ifid_stall, idex_stall, exmem_stall,
                ifid_flush, idex_flush, memwb_flush, pc_redirect};
    endfunction

    // Expected control word per action: 0 run, 1 load stall, 2 flush, 3 memory wait.
    function automatic logic [7:0] act_vec(input int act);
        case (act)
            1:       return 8'b1100_0100;
            2:       return 8'b0000_1101;
            3:       return 8'b1111_0010;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // Reference model: previous action, length of the current wait run, sticky timeout.
    int m_prev = 0;
    int m_run  = 0;
    bit m_to   = 1'b0;
    int m_cnt[4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (!done) begin
            int  act;
            bit  match;
            match = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
            if (mem_req && !mem_ready) act = 3;
            else if (ex_redirect) act = 2;
            else if (ex_hazard && ex_reg_write && ex_rd != 0 && match && m_prev != 1) act = 1;
            else act = 0;
            chk("model_state", 32'(hazard_state), 32'(m_prev));
            chk("model_timeout", 32'(mem_timeout), 32'(m_to));
`ifdef HAZARD_PERF_EN
            chk("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt[1] % (1 << CW)));
            chk("model_flush_cnt", 32'(flush_cnt), 32'(m_cnt[2] % (1 << CW)));
            chk("model_wait_cnt", 32'(wait_cnt), 32'(m_cnt[3] % (1 << CW)));
`endif
            if (rst) begin
                chk("model_outs_rst", 32'(out_vec()), 32'h0);
                m_prev = 0;
                m_run  = 0;
                m_to   = 1'b0;
                m_cnt  = '{0, 0, 0, 0};
            end else begin
                chk("model_outs", 32'(out_vec()), 32'(act_vec(act)));
                m_prev = act;
                m_cnt[act]++;
                if (act == 3) begin
                    m_run++;
                    if (m_run > WT) m_to = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rs1 = '0; id_rs2 = '0;
        ex_hazard = 1'b0; ex_reg_write = 1'b0; ex_rd = '0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_hazard = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    int burst = 0;

    initial begin
        // Reset held while a memory wait is requested: outputs stay quiet.
        idle();
        mem_req = 1'b1; mem_ready = 1'b0;
        #2;
        chk("rst_outs", 32'(out_vec()), 32'h0);
        cyc(); cyc();
        chk("rst_state", 32'(hazard_state), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        idle();
        rst = 1'b0;

        // Load-use gives exactly one bubble.
        load_use(5'd5);
        #1;
        chk("lu_first", 32'(out_vec()), 32'h0000_00c4);
        cyc(); #1;
        chk("lu_second", 32'(out_vec()), 32'h0);
        chk("lu_state", 32'(hazard_state), 32'd1);
        cyc(); idle();
        load_use(5'd0);
        #1;
        chk("lu_rd_zero", 32'(out_vec()), 32'h0);
        cyc(); idle();
        load_use(5'd5); ex_hazard = 1'b0;
        #1;
        chk("lu_not_load", 32'(out_vec()), 32'h0);

        // Redirect alone, then held under a memory wait, then released.
        cyc(); idle();
        ex_redirect = 1'b1;
        #1;
        chk("redir", 32'(out_vec()), 32'h0000_000d);
        cyc();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("redir_frozen", 32'(out_vec()), 32'h0000_00f2);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("redir_release", 32'(out_vec()), 32'h0000_000d);
        cyc(); idle();

        // Watchdog: the fifth consecutive wait edge raises mem_timeout.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("wd_before", 32'(mem_timeout), 32'd0);
        cyc();
        chk("wd_after", 32'(mem_timeout), 32'd1);
        mem_ready = 1'b1;
        cyc(); cyc();
        chk("wd_sticky", 32'(mem_timeout), 32'd1);

        // Reset mid-wait aborts the freeze in the same cycle.
        mem_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("midrst_outs", 32'(out_vec()), 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst_state", 32'(hazard_state), 32'd0);
        chk("midrst_timeout", 32'(mem_timeout), 32'd0);
        // Wait counter restarted: four waits are still short of the timeout.
        for (int i = 0; i < 4; i++) cyc();
        chk("midrst_cnt", 32'(mem_timeout), 32'd0);
        idle();

`ifdef HAZARD_PERF_EN
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            load_use(5'd5); cyc(); cyc();
        end
        idle();
        chk("perf_wrap", 32'(stall_cnt), 32'd1);
        cyc();
`endif

        // Randomized phase against the model.
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            ex_hazard    = ($urandom_range(0, 1) == 0);
            ex_reg_write = ($urandom_range(0, 3) != 0);
            ex_rd        = 5'($urandom_range(0, 3));
            ex_redirect  = ($urandom_range(0, 4) == 0);
            if (burst == 0 && $urandom_range(0, 149) == 0) burst = WT + 2;
            if (burst > 0) begin
                mem_req = 1'b1; mem_ready = 1'b0; burst--;
            end else begin
                mem_req   = ($urandom_range(0, 2) == 0);
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            cyc();
        end

        @(posedge clk);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage pipelined core, sitting directly downstream of the decode-stage control unit. It consumes that unit's registered `hazard` flag (set only for loads), the destination register, and the register-write enable of the instruction in EX. From these, the EX branch/jump redirect and the data-memory handshake, it produces per-stage stall and flush controls. A small FSM records the action taken each cycle, blocks back-to-back load-use stalls and runs a memory-wait watchdog.

## Interface
Parameters:
- `WAIT_TIMEOUT`, default 255: consecutive MEM_WAIT cycles after which `mem_timeout` sets.
- `CNT_W`, default 32: width of the performance counters (used only with the configuration macro).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction actually reads that source.
- `ex_hazard` in 1: control-unit `hazard` flag registered into EX (instruction in EX is a load).
- `ex_reg_write` in 1: `register_write_en` of the EX instruction.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_redirect` in 1: branch taken or jal/jalr in EX.
- `mem_req` in 1: the MEM instruction accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` out 1 each: hold the PC or the named pipeline register.
- `ifid_flush`, `idex_flush`, `memwb_flush` out 1 each: load a bubble (all write enables 0) into the named register.
- `pc_redirect` out 1: PC loads the EX target.
- `hazard_state` out 2: registered FSM state.
- `mem_timeout` out 1: sticky watchdog error.

## Operation
- Priority, evaluated combinationally each cycle: MEM_WAIT > FLUSH > LOAD_STALL > RUN.
- MEM_WAIT condition: `mem_req && !mem_ready`.
  - Asserts `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` and `memwb_flush`.
  - `pc_redirect` is forced 0; a pending redirect is held because EX is frozen.
- FLUSH condition: `ex_redirect` and not MEM_WAIT.
  - Asserts `pc_redirect`, `ifid_flush`, `idex_flush`.
  - No stall outputs are asserted.
- LOAD_STALL condition, all of the following true, and neither of the above:
  - `ex_hazard && ex_reg_write && ex_rd != 0`
  - `(id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)`
  - `hazard_state != LOAD_STALL`
  - Action: assert `pc_stall`, `ifid_stall`, `idex_flush`, giving exactly one bubble.
- RUN: all control outputs 0.
- FSM: `hazard_state` registers the condition selected this cycle. Encoding: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- Load-use detection is suppressed for one cycle after LOAD_STALL, so a stale EX load can never produce a second bubble.
- Watchdog:
  - A wait counter of width `$clog2(WAIT_TIMEOUT+1)` increments on each MEM_WAIT cycle.
  - It clears on any non-MEM_WAIT cycle.
  - When it equals `WAIT_TIMEOUT` while still in MEM_WAIT, `mem_timeout` sets and stays set until `rst`.
  - The counter saturates at `WAIT_TIMEOUT`.

## Timing
- Stall, flush and redirect outputs are combinational (Mealy) from inputs and `hazard_state`, and take effect at the same rising edge.
- `hazard_state` and `mem_timeout` are registered with one-cycle latency.
- Reset:
  - `hazard_state`=RUN, wait counter 0, `mem_timeout`=0, perf counters 0.
  - While `rst` is high, all stall, flush and redirect outputs are forced 0.
- Reset asserted mid-MEM_WAIT or mid-stall aborts it in the same cycle; the first post-reset cycle evaluates from RUN.
- Simultaneous events:
  - MEM_WAIT with redirect: freeze only; the redirect is taken on the first ready cycle.
  - Redirect with load-use match: flush only; the ID instruction is discarded, so no stall is needed.
- `ex_rd == 0` never stalls.

## Configuration
- `HAZARD_PERF_EN` defined:
  - Adds `CNT_W`-bit output ports `stall_cnt`, `flush_cnt`, `wait_cnt`.
  - Each increments once per cycle spent in LOAD_STALL, FLUSH or MEM_WAIT respectively.
  - Counters wrap modulo 2^CNT_W and clear on `rst`.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `hazard_pkg` holds:
  - the `hazard_state_t` enum (2-bit, encoding above);
  - the `REG_ZERO` constant (5'd0);
  - the default `WAIT_TIMEOUT`.
- Sub-module `perf_counter`, parameterised by width, with clock/reset/increment.
  - Instantiated three times, only under `HAZARD_PERF_EN`.

## Test plan
- Load-use: `ex_hazard`=1, `ex_reg_write`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → `pc_stall`=`ifid_stall`=`idex_flush`=1 for exactly one cycle; next cycle with identical inputs → all 0 and `hazard_state`=1.
- Zero-register and non-load cases: same as above but `ex_rd`=0, or `ex_hazard`=0 → no stall.
- Redirect: `ex_redirect`=1 → `pc_redirect`=`ifid_flush`=`idex_flush`=1 and no stalls; held for 3 cycles together with `mem_req`=1, `mem_ready`=0 → freeze only; on `mem_ready`=1 the redirect fires in that cycle.
- Watchdog with `WAIT_TIMEOUT`=4: `mem_req`=1, `mem_ready`=0 held for 5 cycles → `mem_timeout` rises after the 5th edge; it stays 1 after `mem_ready`=1 until `rst`.
- Mid-stall reset: assert `rst` during MEM_WAIT → outputs 0 in the same cycle; after release `hazard_state`=0 and the wait counter is 0.
- With `HAZARD_PERF_EN`: 2 load-use stalls, 3 redirects and 7 wait cycles → `stall_cnt`=2, `flush_cnt`=3, `wait_cnt`=7; with `CNT_W`=3, 9 stalls → `stall_cnt`=1.
